// File: rtl/scan_pattern_ctrl_if.sv
// Serial pattern controller bus: tester-side (master) and controller-side (slave) views.
// Expected/Mismatch exist only when SCAN_COMPARE_EN is defined.
interface scan_pattern_ctrl_if #(
  parameter int InWidth  = 4,
  parameter int OutWidth = 3
);
  logic                Start;
  logic                SerIn;
  logic [InWidth-1:0]  DutIn;
  logic [OutWidth-1:0] DutOut;
  logic                SerOut;
  logic                SerOutValid;
  logic                Ready;
  logic                Done;
`ifdef SCAN_COMPARE_EN
  logic [OutWidth-1:0] Expected;
  logic                Mismatch;

  modport master (
    output Start, SerIn, DutOut, Expected,
    input  DutIn, SerOut, SerOutValid, Ready, Done, Mismatch
  );
  modport slave (
    input  Start, SerIn, DutOut, Expected,
    output DutIn, SerOut, SerOutValid, Ready, Done, Mismatch
  );
`else
  modport master (
    output Start, SerIn, DutOut,
    input  DutIn, SerOut, SerOutValid, Ready, Done
  );
  modport slave (
    input  Start, SerIn, DutOut,
    output DutIn, SerOut, SerOutValid, Ready, Done
  );
`endif
endinterface

// File: rtl/scan_pattern_ctrl.sv
// Serial scan pattern controller: shift in, apply, settle, capture, shift out.
// Optional response compare enabled by the SCAN_COMPARE_EN macro.
module scan_pattern_ctrl #(
  parameter int InWidth     = 4,
  parameter int OutWidth    = 3,
  parameter int CaptureWait = 2
) (
  input logic               Clk,
  input logic               Clr,
  scan_pattern_ctrl_if.slave bus
);

  localparam int CntMax0 = (InWidth > OutWidth) ? InWidth : OutWidth;
  localparam int CntMax  = (CntMax0 > CaptureWait + 1) ?
                           CntMax0 : CaptureWait + 1;
  localparam int CntW    = $clog2(CntMax + 1);
  localparam int WaitL   = (CaptureWait > 0) ? CaptureWait - 1 : 0;

  localparam logic [CntW-1:0] InLast   = CntW'(InWidth - 1);
  localparam logic [CntW-1:0] OutCount = CntW'(OutWidth);
  localparam logic [CntW-1:0] WaitLast = CntW'(WaitL);
  localparam logic [CntW-1:0] One      = CntW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_WAIT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t              state;
  logic [CntW-1:0]     cnt;
  logic [InWidth-1:0]  in_sr;
  logic [OutWidth-1:0] out_sr;
  logic [InWidth-1:0]  dut_in;
  logic                ser_out;
  logic                ser_valid;
  logic                ready;
  logic                done;
`ifdef SCAN_COMPARE_EN
  logic [OutWidth-1:0] exp_q;
  logic                mismatch;
`endif

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state     <= S_IDLE;
      cnt       <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      dut_in    <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
`ifdef SCAN_COMPARE_EN
      exp_q     <= '0;
      mismatch  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.Start) begin
            state <= S_LOAD;
            cnt   <= '0;
            ready <= 1'b0;
`ifdef SCAN_COMPARE_EN
            exp_q    <= bus.Expected;
            mismatch <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          in_sr <= (in_sr << 1) | InWidth'(bus.SerIn);
          if (cnt == InLast) begin
            state <= S_APPLY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + One;
          end
        end
        S_APPLY: begin
          dut_in <= in_sr;
          cnt    <= '0;
          state  <= (CaptureWait > 0) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          if (cnt == WaitLast) begin
            state <= S_CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + One;
          end
        end
        S_CAPTURE: begin
          out_sr <= bus.DutOut;
          cnt    <= '0;
          state  <= S_UNLOAD;
`ifdef SCAN_COMPARE_EN
          mismatch <= (bus.DutOut != exp_q);
`endif
        end
        S_UNLOAD: begin
          // one extra edge after the last bit retires SerOut and raises Done
          if (cnt == OutCount) begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            ser_out   <= out_sr[OutWidth-1];
            ser_valid <= 1'b1;
            out_sr    <= out_sr << 1;
            cnt       <= cnt + One;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.DutIn       = dut_in;
  assign bus.SerOut      = ser_out;
  assign bus.SerOutValid = ser_valid;
  assign bus.Ready       = ready;
  assign bus.Done        = done;
`ifdef SCAN_COMPARE_EN
  assign bus.Mismatch    = mismatch;
`endif

endmodule

// File: tb/tb_scan_pattern_ctrl.sv
// Directed bench: instance a uses CaptureWait=2 with a 2-stage DUT model,
// instance b uses CaptureWait=0 with a combinational loopback.
module tb_scan_pattern_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_pattern_ctrl_if #(.InWidth(4), .OutWidth(3)) a ();
  scan_pattern_ctrl_if #(.InWidth(4), .OutWidth(3)) b ();

  scan_pattern_ctrl #(
    .InWidth(4), .OutWidth(3), .CaptureWait(2)
  ) u_a (
    .Clk(clk), .Clr(clr), .bus(a.slave)
  );

  scan_pattern_ctrl #(
    .InWidth(4), .OutWidth(3), .CaptureWait(0)
  ) u_b (
    .Clk(clk), .Clr(clr), .bus(b.slave)
  );

  logic [2:0] m1 = '0;
  logic [2:0] m2 = '0;
  always_ff @(posedge clk) begin
    m1 <= a.DutIn[3:1];
    m2 <= m1;
  end
  assign a.DutOut = m2;
  assign b.DutOut = b.DutIn[3:1];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Entered just after an edge with a.Ready=1; leaves one cycle after Done.
  task automatic pattern_a(input logic [3:0] pat,
                           input logic [2:0] resp,
                           input logic [2:0] exp_v,
                           input bit glitch);
`ifdef SCAN_COMPARE_EN
    a.Expected = exp_v;
`endif
    a.Start = 1'b1;
    step;
    a.Start = 1'b0;
`ifdef SCAN_COMPARE_EN
    a.Expected = ~exp_v;
    chk("mm_clr_at_start", a.Mismatch, 0);
`endif
    chk("ready_low", a.Ready, 0);
    for (int i = 0; i < 4; i++) begin
      a.SerIn = pat[3-i];
      if (glitch && i == 1) a.Start = 1'b1;
      step;
      a.Start = 1'b0;
    end
    step;
    chk("dut_in", a.DutIn, pat);
    step;
    step;
    step;
    chk("valid_at_capture", a.SerOutValid, 0);
`ifdef SCAN_COMPARE_EN
    chk("mismatch", a.Mismatch, (resp != exp_v));
`endif
    for (int i = 0; i < 3; i++) begin
      step;
      a.Start = 1'b0;
      chk("ser_valid", a.SerOutValid, 1);
      chk("ser_out", a.SerOut, resp[2-i]);
      chk("no_done", a.Done, 0);
      if (glitch && i == 0) a.Start = 1'b1;
    end
    step;
    a.Start = 1'b0;
    chk("done_pulse", a.Done, 1);
    chk("valid_off", a.SerOutValid, 0);
    chk("ser_out_zero", a.SerOut, 0);
    chk("ready_in_done", a.Ready, 0);
    step;
    chk("done_cleared", a.Done, 0);
    chk("ready_back", a.Ready, 1);
    chk("dut_in_hold", a.DutIn, pat);
`ifdef SCAN_COMPARE_EN
    chk("mismatch_hold", a.Mismatch, (resp != exp_v));
`endif
  endtask

  task automatic pattern_b(input logic [3:0] pat,
                           input logic [2:0] resp);
    int done_at;
    int nb;
    logic [2:0] bits;
    done_at = 0;
    nb = 0;
    bits = '0;
    b.Start = 1'b1;
    step;
    b.Start = 1'b0;
    for (int i = 1; i <= 30 && done_at == 0; i++) begin
      if (i <= 4) b.SerIn = pat[4-i];
      step;
      if (b.SerOutValid) begin
        bits = {bits[1:0], b.SerOut};
        nb++;
      end
      if (b.Done) done_at = i;
    end
    chk("b_done_at", done_at, 10);
    chk("b_bits", bits, resp);
    chk("b_nbits", nb, 3);
    chk("b_dut_in", b.DutIn, pat);
    step;
    chk("b_ready", b.Ready, 1);
  endtask

  initial begin
    a.Start = 1'b0;
    a.SerIn = 1'b0;
    b.Start = 1'b0;
    b.SerIn = 1'b0;
`ifdef SCAN_COMPARE_EN
    a.Expected = '0;
    b.Expected = '0;
`endif
    clr = 1'b1;
    step;
    step;
    clr = 1'b0;
    chk("rst_dut_in", a.DutIn, 0);
    chk("rst_ser_out", a.SerOut, 0);
    chk("rst_valid", a.SerOutValid, 0);
    chk("rst_done", a.Done, 0);
    chk("rst_ready", a.Ready, 1);
    chk("rst_b_ready", b.Ready, 1);
`ifdef SCAN_COMPARE_EN
    chk("rst_mismatch", a.Mismatch, 0);
`endif

    pattern_a(4'b1011, 3'b101, 3'b101, 1'b0);
    pattern_a(4'b0110, 3'b011, 3'b100, 1'b1);
    pattern_a(4'b1011, 3'b101, 3'b100, 1'b0);

    // abort during WAIT
    a.Start = 1'b1;
    step;
    a.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a.SerIn = (i < 2);
      step;
    end
    step;
    chk("abort_dut_in_pre", a.DutIn, 4'b1100);
    step;
    clr = 1'b1;
    step;
    clr = 1'b0;
    chk("abort_dut_in", a.DutIn, 0);
    chk("abort_ready", a.Ready, 1);
    chk("abort_done", a.Done, 0);
    chk("abort_valid", a.SerOutValid, 0);
    for (int i = 0; i < 8; i++) begin
      step;
      chk("abort_quiet", {a.Done, a.SerOutValid}, 0);
    end

    // Clr beats Start at the same edge
    clr = 1'b1;
    a.Start = 1'b1;
    step;
    clr = 1'b0;
    a.Start = 1'b0;
    step;
    chk("clr_over_start", a.Ready, 1);

    pattern_b(4'b1111, 3'b111);
    pattern_b(4'b0101, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
